// File: rtl/sc_nonoverlap_phase_gen_pkg.sv
// sc_nonoverlap_phase_gen_pkg: shared types, defaults and config legality check for the phase generator
package sc_nonoverlap_phase_gen_pkg;
  typedef enum logic [2:0] {IDLE, P1, D12, P2, D21} phase_state_t;
  localparam int CNT_W_DEF = 8;
  localparam int DEAD_MIN_DEF = 1;
  typedef struct packed {
    logic [CNT_W_DEF-1:0] half_period;
    logic [CNT_W_DEF-1:0] dead_time;
    logic [CNT_W_DEF-1:0] early_lead;
  } sc_phase_cfg_t;
  function automatic logic cfg_legal(input logic [31:0] hp, input logic [31:0] dt,
                                     input logic [31:0] el, input logic [31:0] dmin);
    return (hp != 0) && (hp > el) && (dt >= dmin);
  endfunction
endpackage

// File: rtl/sc_nonoverlap_phase_gen_timer.sv
// sc_nonoverlap_phase_gen_timer: loadable down-counter timing each phase state, exposes its next count
module sc_nonoverlap_phase_gen_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cnt_nxt
);
  logic [CNT_W-1:0] r_cnt;
  assign o_cnt_nxt = i_load ? i_load_val : (r_cnt != '0 ? r_cnt - CNT_W'(1) : r_cnt);
  assign o_done = r_cnt == CNT_W'(1);
  // count register: loads a duration, then counts down and parks at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= o_cnt_nxt;
endmodule

// File: rtl/sc_nonoverlap_phase_gen.sv
// sc_nonoverlap_phase_gen: programmable non-overlapping two-phase clock generator with per-channel gating
module sc_nonoverlap_phase_gen
  import sc_nonoverlap_phase_gen_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int NUM_CH   = 2,
  parameter int DEAD_MIN = DEAD_MIN_DEF,
  parameter int CYC_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [CNT_W-1:0]  i_half_period,
  input  logic [CNT_W-1:0]  i_dead_time,
  input  logic [CNT_W-1:0]  i_early_lead,
  input  logic [NUM_CH-1:0] i_ch_mask,
  output logic [NUM_CH-1:0] o_phi1,
  output logic [NUM_CH-1:0] o_phi2,
  output logic [NUM_CH-1:0] o_phi1e,
  output logic [NUM_CH-1:0] o_phi2e,
  output logic              o_busy,
  output logic              o_cfg_err,
  output logic [CYC_W-1:0]  o_cyc_cnt
);
  phase_state_t r_state, w_nxt;
  logic [CNT_W-1:0] r_hp, r_dt, r_el, w_hp_n, w_dt_n, w_el_n, w_ld_val, w_cnt_n;
  logic [NUM_CH-1:0] r_mask, w_mask_n;
  logic w_load, w_take, w_set_err, w_inc, w_done, w_legal;

  sc_nonoverlap_phase_gen_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_load_val(w_ld_val),
    .o_done(w_done), .o_cnt_nxt(w_cnt_n)
  );

  // next state, timer reload and shadow update; config is only sampled in IDLE and at the end of D21
  always_comb begin
    w_legal = cfg_legal(32'(i_half_period), 32'(i_dead_time), 32'(i_early_lead), 32'(DEAD_MIN));
    w_nxt = r_state;
    w_load = 1'b0;
    w_ld_val = r_hp;
    w_take = 1'b0;
    w_set_err = 1'b0;
    w_inc = 1'b0;
    case (r_state)
      IDLE: if (i_en) begin
        w_take = w_legal;
        w_set_err = !w_legal;
        w_load = w_legal;
        w_ld_val = i_half_period;
        w_nxt = w_legal ? P1 : IDLE;
      end
      P1: if (w_done) begin
        w_nxt = D12;
        w_load = 1'b1;
        w_ld_val = r_dt;
      end
      D12: if (w_done) begin
        w_nxt = P2;
        w_load = 1'b1;
      end
      P2: if (w_done) begin
        w_nxt = D21;
        w_load = 1'b1;
        w_ld_val = r_dt;
      end
      D21: if (w_done) begin
        w_inc = 1'b1;
        w_nxt = i_en ? P1 : IDLE;
        w_load = i_en;
        w_take = i_en && w_legal;
        w_set_err = i_en && !w_legal;
        w_ld_val = w_legal ? i_half_period : r_hp;
      end
      default: w_nxt = IDLE;
    endcase
    w_hp_n = w_take ? i_half_period : r_hp;
    w_dt_n = w_take ? i_dead_time : r_dt;
    w_el_n = w_take ? i_early_lead : r_el;
    w_mask_n = w_take ? i_ch_mask : r_mask;
  end

  // state, shadow config and registered phase outputs decoded from the upcoming state and count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_hp <= '0;
      r_dt <= '0;
      r_el <= '0;
      r_mask <= '0;
      o_phi1 <= '0;
      o_phi2 <= '0;
      o_phi1e <= '0;
      o_phi2e <= '0;
      o_busy <= 1'b0;
      o_cfg_err <= 1'b0;
      o_cyc_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_hp <= w_hp_n;
      r_dt <= w_dt_n;
      r_el <= w_el_n;
      r_mask <= w_mask_n;
      o_phi1 <= w_nxt == P1 ? w_mask_n : '0;
      o_phi2 <= w_nxt == P2 ? w_mask_n : '0;
      o_phi1e <= (w_nxt == P1 && w_cnt_n > w_el_n) ? w_mask_n : '0;
      o_phi2e <= (w_nxt == P2 && w_cnt_n > w_el_n) ? w_mask_n : '0;
      o_busy <= w_nxt != IDLE;
      o_cfg_err <= w_take ? 1'b0 : (w_set_err ? 1'b1 : o_cfg_err);
      o_cyc_cnt <= o_cyc_cnt + CYC_W'(w_inc);
    end
endmodule

// File: tb/tb_sc_nonoverlap_phase_gen.sv
// tb_sc_nonoverlap_phase_gen: directed scenarios for the two-phase generator with a running invariant monitor
module tb_sc_nonoverlap_phase_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0] hp = '0, dt = '0, el = '0;
  logic [1:0] mask = '0;
  logic [1:0] phi1, phi2, phi1e, phi2e, prev_phi1, prev_phi2;
  logic busy, cfg_err;
  logic [3:0] cyc;
  logic [7:0] obs, exp_v;
  int checks = 0;
  int errors = 0;

  assign obs = {phi1, phi1e, phi2, phi2e};

  sc_nonoverlap_phase_gen #(.CNT_W(8), .NUM_CH(2), .DEAD_MIN(1), .CYC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_half_period(hp), .i_dead_time(dt),
    .i_early_lead(el), .i_ch_mask(mask), .o_phi1(phi1), .o_phi2(phi2),
    .o_phi1e(phi1e), .o_phi2e(phi2e), .o_busy(busy), .o_cfg_err(cfg_err), .o_cyc_cnt(cyc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(int k, int h, int d, int e, logic [1:0] m);
    int p;
    p = k % (2 * (h + d));
    model = {(p < h) ? m : 2'b00, (p < h - e) ? m : 2'b00,
             (p >= h + d && p < 2 * h + d) ? m : 2'b00,
             (p >= h + d && p < 2 * h + d - e) ? m : 2'b00};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((phi1 & phi2) !== 2'b00 || (phi1e & ~phi1) !== 2'b00 || (phi2e & ~phi2) !== 2'b00 ||
          (prev_phi1 & phi2) !== 2'b00 || (prev_phi2 & phi1) !== 2'b00) begin
        errors++;
        $display("FAIL invariant t=%0t phi1=%b phi1e=%b phi2=%b phi2e=%b prev1=%b prev2=%b",
                 $time, phi1, phi1e, phi2, phi2e, prev_phi1, prev_phi2);
      end
    end
    prev_phi1 = rst_n ? phi1 : 2'b00;
    prev_phi2 = rst_n ? phi2 : 2'b00;
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({obs, busy, cfg_err, cyc} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state got %b required 0", {obs, busy, cfg_err, cyc});
    end
    hp = 8'd4; dt = 8'd2; el = 8'd1; mask = 2'b11; en = 1'b1;
    @(negedge clk);
    checks++;
    if ({obs, busy} !== 9'd0) begin
      errors++;
      $display("FAIL reset_hold got %b required 0", {obs, busy});
    end
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({obs, busy, cfg_err, cyc} !== 14'd0) begin
      errors++;
      $display("FAIL idle_after_reset got %b required 0", {obs, busy, cfg_err, cyc});
    end
  endtask

  task automatic test_basic();
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      exp_v = model(k, 4, 2, 1, 2'b11);
      checks++;
      if (obs !== exp_v || busy !== 1'b1 || cyc !== 4'(k / 12)) begin
        errors++;
        $display("FAIL basic k=%0d got %b busy=%b cyc=%0d required %b busy=1 cyc=%0d",
                 k, obs, busy, cyc, exp_v, k / 12);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_en_drop();
    for (int k = 24; k < 36; k++) begin
      exp_v = model(k, 4, 2, 1, 2'b11);
      checks++;
      if (obs !== exp_v || busy !== 1'b1 || cyc !== 4'd2) begin
        errors++;
        $display("FAIL en_drop k=%0d got %b busy=%b cyc=%0d required %b busy=1 cyc=2",
                 k, obs, busy, cyc, exp_v);
      end
      if (k == 31) en = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({obs, busy} !== 9'd0 || cyc !== 4'd3) begin
        errors++;
        $display("FAIL en_drop_idle got %b busy=%b cyc=%0d required 0 busy=0 cyc=3", obs, busy, cyc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cfg_err();
    dt = 8'd0;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || obs !== 8'd0) begin
        errors++;
        $display("FAIL cfg_err_set k=%0d got err=%b busy=%b phases=%b required err=1 busy=0 phases=0",
                 k, cfg_err, busy, obs);
      end
    end
    dt = 8'd2;
    mask = 2'b01;
    @(negedge clk);
    exp_v = model(0, 4, 2, 1, 2'b01);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1 || obs !== exp_v || cyc !== 4'd3) begin
      errors++;
      $display("FAIL cfg_err_clear got err=%b busy=%b phases=%b cyc=%0d required err=0 busy=1 phases=%b cyc=3",
               cfg_err, busy, obs, cyc, exp_v);
    end
  endtask

  task automatic test_mask();
    for (int k = 1; k < 25; k++) begin
      @(negedge clk);
      exp_v = model(k, 4, 2, 1, k < 12 ? 2'b01 : 2'b10);
      checks++;
      if (obs !== exp_v || cyc !== 4'(3 + k / 12)) begin
        errors++;
        $display("FAIL mask k=%0d got %b cyc=%0d required %b cyc=%0d", k, obs, cyc, exp_v, 3 + k / 12);
      end
      if (k == 1) mask = 2'b10;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    checks++;
    if (phi1 !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_pre got phi1=%b required 10", phi1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, busy, cfg_err, cyc} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_async got %b required 0", {obs, busy, cfg_err, cyc});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_v = model(0, 4, 2, 1, 2'b10);
    checks++;
    if (obs !== exp_v || busy !== 1'b1 || cyc !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_restart got %b busy=%b cyc=%0d required %b busy=1 cyc=0", obs, busy, cyc, exp_v);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k <= 204; k++) begin
      exp_v = model(k, 4, 2, 1, 2'b10);
      checks++;
      if (obs !== exp_v || cyc !== 4'(k / 12)) begin
        errors++;
        $display("FAIL wrap k=%0d got %b cyc=%0d required %b cyc=%0d", k, obs, cyc, exp_v, (k / 12) % 16);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_resample();
    repeat (10) @(negedge clk);
    checks++;
    if (obs !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resample_pre got %b busy=%b required 0 busy=1", obs, busy);
    end
    hp = 8'd3; dt = 8'd1; el = 8'd0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      exp_v = model(j, 3, 1, 0, 2'b10);
      checks++;
      if (obs !== exp_v || cyc !== 4'(2 + j / 8) || cfg_err !== (j >= 8)) begin
        errors++;
        $display("FAIL resample j=%0d got %b cyc=%0d err=%b required %b cyc=%0d err=%b",
                 j, obs, cyc, cfg_err, exp_v, 2 + j / 8, j >= 8);
      end
      if (j == 7) begin
        hp = 8'd1;
        el = 8'd1;
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_en_drop();
    test_cfg_err();
    test_mask();
    test_reset_mid();
    test_wrap();
    test_resample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
